reg_file_ctrl_fsm: RTL

//   Multi-cycle control sequencer directly upstream of the 4x10-bit register file.

---
 rtl/reg_file_ctrl_fsm.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/reg_file_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// reg_file_ctrl_fsm
//   Multi-cycle control sequencer in front of the 4x10-bit register file.
//   Captures one instruction per Exec handshake in IDLE, decodes it and
//   steps the register file, ALU result latch G and the shared data bus D
//   through LOAD, COPY, ADD/SUB/AND/OR/XOR and NOT, then pulses Done.
//
//   Instruction format: [9:8] X (dest), [7:6] Y (src), [5:4] reserved (00),
//   [3:0] opcode. Opcodes 8-15 or a non-zero reserved field fault.
//
//   Build option: RFCTRL_ILLEGAL_TRAP_EN
//     defined   - a fault parks in a trap (Err=1, Busy=1) until Rstb.
//     undefined - a fault is a one-cycle Done+Err pulse, then IDLE.
//
// Parameters
//   DW      instruction/data width (only 10 is supported)
//   LD_TMO  LDW cycles without DValid before a fault; 0 waits forever
//
// Ports
//   CLKb    in   clock, rising edge
//   Rstb    in   asynchronous active-low reset
//   Exec    in   start request, sampled only in IDLE
//   Instr   in   instruction, captured on Exec in IDLE
//   DValid  in   external LOAD data valid
//   ENW/WRA        out  register-file write enable / address
//   ENR0/RDA0      out  read port Q0 enable / address
//   ENR1/RDA1      out  read port Q1 enable / address
//   FN             out  ALU function
//   Gin/Gout       out  latch ALU result into G / drive G onto D
//   Extern         out  drive external data onto D
//   Busy/Done/Err  out  in progress / completion pulse / fault
// ---------------------------------------------------------------------------
module reg_file_ctrl_fsm #(
    parameter int unsigned DW     = 10,
    parameter int unsigned LD_TMO = 15
) (
    input  logic          CLKb,
    input  logic          Rstb,
    input  logic          Exec,
    input  logic [DW-1:0] Instr,
    input  logic          DValid,
    output logic          ENW,
    output logic [1:0]    WRA,
    output logic          ENR0,
    output logic [1:0]    RDA0,
    output logic          ENR1,
    output logic [1:0]    RDA1,
    output logic [2:0]    FN,
    output logic          Gin,
    output logic          Gout,
    output logic          Extern,
    output logic          Busy,
    output logic          Done,
    output logic          Err
);

    localparam int unsigned CW = (LD_TMO < 2) ? 1 : $clog2(LD_TMO + 1);
    localparam logic [CW:0] LD_TMO_W = (CW+1)'(LD_TMO);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEC,
        S_WB,
        S_LDW,
        S_DONE,
        S_FAULT
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [DW-1:0] r_ir;
    logic [CW-1:0] r_cnt;
    logic [CW:0]   w_cnt_inc;
    logic [1:0]    w_x;
    logic [1:0]    w_y;
    logic [3:0]    w_opc;
    logic          w_illegal;

    assign w_x       = r_ir[9:8];
    assign w_y       = r_ir[7:6];
    assign w_opc     = r_ir[3:0];
    assign w_illegal = (r_ir[5:4] != 2'b00) || w_opc[3];
    assign w_cnt_inc = {1'b0, r_cnt} + 1'b1;

    always_ff @(posedge CLKb or negedge Rstb) begin
        if (!Rstb) begin
            r_state <= S_IDLE;
            r_ir    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && Exec)
                r_ir <= Instr;
            // LDW is only entered from DEC, so clearing here clears on entry
            if (r_state == S_DEC)
                r_cnt <= '0;
            else if (r_state == S_LDW && !DValid)
                r_cnt <= w_cnt_inc[CW-1:0];
        end
    end

    always_comb begin
        w_next = r_state;
        ENW    = 1'b0;
        WRA    = 2'b00;
        ENR0   = 1'b0;
        RDA0   = 2'b00;
        ENR1   = 1'b0;
        RDA1   = 2'b00;
        FN     = 3'b000;
        Gin    = 1'b0;
        Gout   = 1'b0;
        Extern = 1'b0;
        Busy   = 1'b0;
        Done   = 1'b0;
        Err    = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (Exec)
                    w_next = S_DEC;
            end

            S_DEC: begin
                Busy = 1'b1;
                if (w_illegal) begin
                    w_next = S_FAULT;
                end else begin
                    unique case (w_opc[2:0])
                        3'd0: w_next = S_LDW;
                        3'd1: begin
                            ENR0   = 1'b1;
                            RDA0   = w_y;
                            ENW    = 1'b1;
                            WRA    = w_x;
                            w_next = S_DONE;
                        end
                        3'd7: begin
                            // NOT is unary: only Y is read, on Q1
                            ENR1   = 1'b1;
                            RDA1   = w_y;
                            FN     = w_opc[2:0];
                            Gin    = 1'b1;
                            w_next = S_WB;
                        end
                        default: begin
                            ENR0   = 1'b1;
                            RDA0   = w_x;
                            ENR1   = 1'b1;
                            RDA1   = w_y;
                            FN     = w_opc[2:0];
                            Gin    = 1'b1;
                            w_next = S_WB;
                        end
                    endcase
                end
            end

            S_WB: begin
                Busy   = 1'b1;
                Gout   = 1'b1;
                ENW    = 1'b1;
                WRA    = w_x;
                w_next = S_DONE;
            end

            S_LDW: begin
                Busy   = 1'b1;
                Extern = 1'b1;
                if (DValid) begin
                    ENW    = 1'b1;
                    WRA    = w_x;
                    w_next = S_DONE;
                end else if (LD_TMO != 0 && w_cnt_inc == LD_TMO_W) begin
                    w_next = S_FAULT;
                end
            end

            S_DONE: begin
                Busy   = 1'b1;
                Done   = 1'b1;
                w_next = S_IDLE;
            end

            S_FAULT: begin
                Busy = 1'b1;
                Err  = 1'b1;
`ifdef RFCTRL_ILLEGAL_TRAP_EN
                w_next = S_FAULT;
`else
                Done   = 1'b1;
                w_next = S_IDLE;
`endif
            end

            default: w_next = S_IDLE;
        endcase
    end

endmodule
